// File: rtl/vote_scheduler_pkg.sv
// Shared definitions for the vote scheduler: FSM state encoding and channel-id width helper.
package vote_scheduler_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Channel id width; a single channel still gets a 1-bit id.
   function automatic int cw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vote_scheduler_if.sv
// Request/result bundle between voting channels, the scheduler and its consumer.
interface vote_scheduler_if
   import vote_scheduler_pkg::*;
#(
   parameter int NCH = 4
);
   localparam int CW = cw_of(NCH);

   logic [NCH-1:0] req;
   logic [NCH-1:0] va;
   logic [NCH-1:0] vb;
   logic [NCH-1:0] vc;
   logic [NCH-1:0] gnt;
   logic           out_valid;
   logic           out_ready;
   logic           out_majo;
   logic [CW-1:0]  out_ch;
   logic           out_dis;

   modport master (
      output req, va, vb, vc, out_ready,
      input  gnt, out_valid, out_majo, out_ch, out_dis
   );

   modport slave (
      input  req, va, vb, vc, out_ready,
      output gnt, out_valid, out_majo, out_ch, out_dis
   );

endinterface

// File: rtl/vote_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first pending request at or after ptr wins.
module rr_arbiter
   import vote_scheduler_pkg::*;
#(
   parameter  int NCH = 4,
   localparam int CW  = cw_of(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic           en,
   input  logic [CW-1:0]  ptr,
   output logic [NCH-1:0] gnt,
   output logic [CW-1:0]  idx,
   output logic           any
);

   logic [CW-1:0] c;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = '0;
      for (int k = 0; k < NCH; k++) begin
         c = CW'((int'(ptr) + k) % NCH);
         if (en && !any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = c;
         end
      end
   end

endmodule

// File: rtl/vote_scheduler.sv
// Shares one 2-of-3 majority voter among NCH channels behind a round-robin arbiter.
// Optional saturating disagreement counter on err_cnt when VOTE_ERRCNT_EN is defined.
module vote_scheduler
   import vote_scheduler_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int CNTW = 8
) (
   input logic             clk,
   input logic             rst_n,
   vote_scheduler_if.slave vif
`ifdef VOTE_ERRCNT_EN
   ,
   output logic [CNTW-1:0] err_cnt
`endif
);

   localparam int CW = cw_of(NCH);

   if (NCH < 1 || NCH > 16 || CNTW < 1) begin : g_bad_param
      $error("vote_scheduler: NCH must be 1..16 and CNTW >= 1");
   end

   state_t         state, state_nx;
   logic [CW-1:0]  ptr, idx;
   logic [NCH-1:0] gnt;
   logic           any, win;
   logic           sa, sb, sc, cap_dis;
   logic           majo_q, dis_q;
   logic [CW-1:0]  ch_q;

   // Reset also closes the window so nothing is granted while held in reset.
   assign win = rst_n & ((state == IDLE) | vif.out_ready);

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req (vif.req),
      .en  (win),
      .ptr (ptr),
      .gnt (gnt),
      .idx (idx),
      .any (any)
   );

   assign sa      = vif.va[idx];
   assign sb      = vif.vb[idx];
   assign sc      = vif.vc[idx];
   assign cap_dis = (sa != sb) | (sb != sc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (win) state_nx = any ? HOLD : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         majo_q <= 1'b0;
         dis_q  <= 1'b0;
         ch_q   <= '0;
         ptr    <= '0;
      end else if (any) begin
         majo_q <= (sa & sb) | (sb & sc) | (sc & sa);
         dis_q  <= cap_dis;
         ch_q   <= idx;
         ptr    <= (int'(idx) == NCH - 1) ? '0 : idx + CW'(1);
      end
   end

`ifdef VOTE_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (any && cap_dis && (err_cnt != {CNTW{1'b1}}))
         err_cnt <= err_cnt + CNTW'(1);
   end
`endif

   assign vif.gnt       = gnt;
   assign vif.out_valid = (state == HOLD);
   assign vif.out_majo  = majo_q;
   assign vif.out_ch    = ch_q;
   assign vif.out_dis   = dis_q;

endmodule

// File: tb/tb_vote_scheduler.sv
// Directed bench for vote_scheduler (NCH=4, CNTW=2); counter checks only with VOTE_ERRCNT_EN.
module tb_vote_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   vote_scheduler_if #(.NCH(4)) vif ();

`ifdef VOTE_ERRCNT_EN
   logic [1:0] err_cnt;
`endif

   vote_scheduler #(.NCH(4), .CNTW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vif   (vif)
`ifdef VOTE_ERRCNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   logic [7:0] majtab;
   logic [3:0] eg;
   logic [2:0] pv;
   logic [1:0] ecnt [5];

   initial begin
      majtab  = 8'b1110_1000;
      ecnt[0] = 2'd1; ecnt[1] = 2'd2; ecnt[2] = 2'd3; ecnt[3] = 2'd3; ecnt[4] = 2'd3;

      // 1: reset with all requests pending
      rst_n = 1'b0;
      vif.req = 4'hF; vif.va = 4'h0; vif.vb = 4'h0; vif.vc = 4'h0; vif.out_ready = 1'b1;
      #2;
      chk("rst_gnt", 32'(vif.gnt), 32'h0);
      chk("rst_valid", 32'(vif.out_valid), 32'h0);
      tick();
      chk("rst_gnt_edge", 32'(vif.gnt), 32'h0);
      chk("rst_ch", 32'(vif.out_ch), 32'h0);
      vif.req = 4'h0;
      rst_n = 1'b1;
`ifdef VOTE_ERRCNT_EN
      #1;
      chk("rst_errcnt", 32'(err_cnt), 32'h0);
`endif

      // 2: single vote on channel 2 with A,B,C = 1,0,1
      tick();
      vif.req = 4'b0100; vif.va = 4'b0100; vif.vb = 4'b0000; vif.vc = 4'b0100;
      #1;
      chk("single_gnt", 32'(vif.gnt), 32'h4);
      tick();
      vif.req = 4'h0;
      chk("single_valid", 32'(vif.out_valid), 32'h1);
      chk("single_majo", 32'(vif.out_majo), 32'h1);
      chk("single_ch", 32'(vif.out_ch), 32'h2);
      chk("single_dis", 32'(vif.out_dis), 32'h1);
      tick();
      chk("single_drain", 32'(vif.out_valid), 32'h0);

      // 3: round robin from pointer 0, back-to-back
      pulse_reset();
      vif.req = 4'hF; vif.va = 4'hF; vif.vb = 4'hF; vif.vc = 4'h0;
      #1;
      for (int k = 0; k < 5; k++) begin
         eg = 4'b0001 << (k % 4);
         chk($sformatf("rr_gnt%0d", k), 32'(vif.gnt), 32'(eg));
         if (k > 0) begin
            chk($sformatf("rr_valid%0d", k), 32'(vif.out_valid), 32'h1);
            chk($sformatf("rr_ch%0d", k), 32'(vif.out_ch), 32'((k - 1) % 4));
         end
         tick();
      end
      chk("rr_last_ch", 32'(vif.out_ch), 32'h0);
      chk("rr_last_valid", 32'(vif.out_valid), 32'h1);
      vif.req = 4'h0;
      tick();

      // 4: backpressure on ch0 result, then ch1 granted on accept
      pulse_reset();
      vif.req = 4'h3; vif.va = 4'h3; vif.vb = 4'h0; vif.vc = 4'h0;
      #1;
      chk("bp_gnt0", 32'(vif.gnt), 32'h1);
      tick();
      vif.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp_hold_gnt%0d", k), 32'(vif.gnt), 32'h0);
         chk($sformatf("bp_hold_v%0d", k),
             {28'h0, vif.out_valid, vif.out_majo, vif.out_dis, vif.out_ch[0]}, 32'hA);
         tick();
      end
      vif.out_ready = 1'b1;
      #1;
      chk("bp_accept_gnt", 32'(vif.gnt), 32'h2);
      tick();
      vif.req = 4'h0;
      chk("bp_ch1", 32'(vif.out_ch), 32'h1);
      chk("bp_ch1_valid", 32'(vif.out_valid), 32'h1);
      tick();
      chk("bp_drain", 32'(vif.out_valid), 32'h0);

      // 5: all eight A,B,C patterns, one capture per cycle
      for (int p = 0; p < 8; p++) begin
         pv = 3'(p);
         vif.req = 4'hF;
         vif.va = {4{pv[2]}}; vif.vb = {4{pv[1]}}; vif.vc = {4{pv[0]}};
         tick();
         chk($sformatf("maj_valid%0d", p), 32'(vif.out_valid), 32'h1);
         chk($sformatf("maj_majo%0d", p), 32'(vif.out_majo), 32'(majtab[p]));
         chk($sformatf("maj_dis%0d", p), 32'(vif.out_dis), (p == 0 || p == 7) ? 32'h0 : 32'h1);
      end
      vif.req = 4'h0;
      tick();

`ifdef VOTE_ERRCNT_EN
      // 6: saturating disagreement counter (CNTW=2)
      pulse_reset();
      #1;
      chk("cnt_clear", 32'(err_cnt), 32'h0);
      vif.req = 4'hF; vif.va = 4'hF; vif.vb = 4'h0; vif.vc = 4'h0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("cnt%0d", k), 32'(err_cnt), 32'(ecnt[k]));
      end
`endif

      // Reset asserted while a result is held
      vif.req = 4'hF; vif.va = 4'hF; vif.vb = 4'h0; vif.vc = 4'h0; vif.out_ready = 1'b1;
      tick();
      vif.out_ready = 1'b0;
      tick();
      chk("midhold_valid_pre", 32'(vif.out_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midhold_valid", 32'(vif.out_valid), 32'h0);
      chk("midhold_gnt", 32'(vif.gnt), 32'h0);
`ifdef VOTE_ERRCNT_EN
      chk("midhold_cnt", 32'(err_cnt), 32'h0);
`endif
      #1;
      rst_n = 1'b1;
      vif.req = 4'h0;
      tick();
      chk("post_reset_valid", 32'(vif.out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
